// File: rtl/relu_maxpool.sv
// Fused ReLU + max-pool over a packed convolution map, one element per clock.
// The element read on one edge is folded into the running max on the next edge.
module relu_maxpool #(
    parameter int DATA_BIT   = 26,
    parameter int IN_WIDTH   = 27,
    parameter int IN_HEIGHT  = 27,
    parameter int POOL       = 2,
    parameter int OUT_WIDTH  = IN_WIDTH / POOL,
    parameter int OUT_HEIGHT = IN_HEIGHT / POOL
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [DATA_BIT*IN_WIDTH*IN_HEIGHT-1:0]    conv_result,
    input  logic                                      conv_done,
    input  logic                                      enable,
    output logic [DATA_BIT*OUT_WIDTH*OUT_HEIGHT-1:0]  pool_result,
    output logic                                      busy,
    output logic                                      done
);
    localparam int CW = 16;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0] dx, dy, p, q;   // read-side position
    logic [CW-1:0] wp, wq;         // write-side window
    logic          rd_done;
    logic          samp_vld, samp_last_win, samp_last_all;
    logic signed [DATA_BIT-1:0] samp, run_max, new_max, elem;
    logic          start, rd_last_win, rd_last_all;
    int            idx, widx;

    assign start = (state != SCAN) && enable && conv_done;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = SCAN;
            SCAN: begin
                busy = 1'b1;
                if (samp_vld && samp_last_all) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = SCAN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        idx         = (int'(q) * POOL + int'(dy)) * IN_WIDTH + int'(p) * POOL + int'(dx);
        widx        = int'(wq) * OUT_WIDTH + int'(wp);
        elem        = conv_result[idx*DATA_BIT +: DATA_BIT];
        new_max     = (samp > run_max) ? samp : run_max;
        rd_last_win = (dx == CW'(POOL - 1)) && (dy == CW'(POOL - 1));
        rd_last_all = rd_last_win && (p == CW'(OUT_WIDTH - 1)) && (q == CW'(OUT_HEIGHT - 1));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dx            <= '0;
            dy            <= '0;
            p             <= '0;
            q             <= '0;
            wp            <= '0;
            wq            <= '0;
            rd_done       <= 1'b0;
            samp_vld      <= 1'b0;
            samp_last_win <= 1'b0;
            samp_last_all <= 1'b0;
            samp          <= '0;
            run_max       <= '0;
            pool_result   <= '0;
        end else if (start) begin
            dx            <= '0;
            dy            <= '0;
            p             <= '0;
            q             <= '0;
            wp            <= '0;
            wq            <= '0;
            rd_done       <= 1'b0;
            samp_vld      <= 1'b0;
            samp_last_win <= 1'b0;
            samp_last_all <= 1'b0;
            run_max       <= '0;
        end else if (state == SCAN) begin
            if (!rd_done) begin
                samp          <= elem;
                samp_vld      <= 1'b1;
                samp_last_win <= rd_last_win;
                samp_last_all <= rd_last_all;
                if (rd_last_all) rd_done <= 1'b1;
                // Raster walk: dx, dy inside a window, then p, q across windows
                if (dx == CW'(POOL - 1)) begin
                    dx <= '0;
                    if (dy == CW'(POOL - 1)) begin
                        dy <= '0;
                        if (p == CW'(OUT_WIDTH - 1)) begin
                            p <= '0;
                            q <= (q == CW'(OUT_HEIGHT - 1)) ? '0 : q + CW'(1);
                        end else begin
                            p <= p + CW'(1);
                        end
                    end else begin
                        dy <= dy + CW'(1);
                    end
                end else begin
                    dx <= dx + CW'(1);
                end
            end else begin
                samp_vld <= 1'b0;
            end

            if (samp_vld) begin
                if (samp_last_win) begin
                    // Max starts at 0 each window, so the stored value is already ReLU'd
                    pool_result[widx*DATA_BIT +: DATA_BIT] <= new_max;
                    run_max <= '0;
                    if (wp == CW'(OUT_WIDTH - 1)) begin
                        wp <= '0;
                        wq <= wq + CW'(1);
                    end else begin
                        wp <= wp + CW'(1);
                    end
                end else begin
                    run_max <= new_max;
                end
            end
        end
    end
endmodule
